// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester memory port arbiter.
// Combinational-free package: widths, requester ids, command stage and lock state.
// No flow control lives here; see mem_arbiter for handshake behaviour.
package mem_arb_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED_A = 2'd1,
        LOCKED_B = 2'd2
    } lock_state_t;

    typedef struct packed {
        logic              v;
        req_id_t           id;
        logic              we;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wd;
    } cmd_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant with a lock mask; grant is combinational, pointer registered.
// Latency: grant in the same cycle as req; pointer updates at the edge of each grant.
// Backpressure: masked or losing requests simply see no grant and wait.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [1:0] mask,
    output logic [1:0] gnt
);

    req_id_t    rr_last;
    logic [1:0] elig;

    always_comb begin
        elig = req & mask;
        gnt  = elig;
        // Contention goes to whichever side did not win the previous transfer.
        if (elig == 2'b11) begin
            gnt = (rr_last == REQ_A) ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= REQ_B;
        end else if (gnt[0]) begin
            rr_last <= REQ_A;
        end else if (gnt[1]) begin
            rr_last <= REQ_B;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory read/write port between requesters A and B; optional grant lock via MEM_ARB_LOCK_EN.
// Latency: accept at edge T, memory driven in cycle T+1, rsp_valid pulse in cycle T+2.
// Backpressure: ready limited only by arbitration (and lock); responses cannot be stalled.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned CAPACITY = 64
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              a_valid,
    output logic              a_ready,
    input  logic              a_we,
    input  logic [WORD_W-1:0] a_addr,
    input  logic [WORD_W-1:0] a_wd,
    input  logic              a_lock,
    output logic              a_rsp_valid,
    output logic [WORD_W-1:0] a_rdata,

    input  logic              b_valid,
    output logic              b_ready,
    input  logic              b_we,
    input  logic [WORD_W-1:0] b_addr,
    input  logic [WORD_W-1:0] b_wd,
    input  logic              b_lock,
    output logic              b_rsp_valid,
    output logic [WORD_W-1:0] b_rdata,

    output logic              mem_we,
    output logic [WORD_W-1:0] mem_rwa,
    output logic [WORD_W-1:0] mem_wd,
    input  logic [WORD_W-1:0] mem_rwd
);

    logic [1:0] gnt;
    logic [1:0] grant_mask;
    cmd_t       cmd_d;
    cmd_t       cmd_q;

    // Range checking belongs to the memory; addresses pass through untouched.
    logic [31:0] unused_capacity;
    assign unused_capacity = CAPACITY;

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({b_valid, a_valid}),
        .mask  (grant_mask),
        .gnt   (gnt)
    );

    // Requesters may hold valid through reset; nothing is accepted while it is asserted.
    assign a_ready = gnt[0] & rst_n;
    assign b_ready = gnt[1] & rst_n;

`ifdef MEM_ARB_LOCK_EN
    lock_state_t lock_q;
    lock_state_t lock_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q <= UNLOCKED;
        end else begin
            lock_q <= lock_d;
        end
    end

    // Only the owner can transfer while locked, so any transfer decides the next owner.
    always_comb begin
        lock_d = lock_q;
        if (a_ready) begin
            lock_d = a_lock ? LOCKED_A : UNLOCKED;
        end else if (b_ready) begin
            lock_d = b_lock ? LOCKED_B : UNLOCKED;
        end
    end

    always_comb begin
        case (lock_q)
            LOCKED_A: grant_mask = 2'b01;
            LOCKED_B: grant_mask = 2'b10;
            default:  grant_mask = 2'b11;
        endcase
    end
`else
    logic unused_lock;
    assign unused_lock = a_lock ^ b_lock;
    assign grant_mask  = 2'b11;
`endif

    always_comb begin
        cmd_d = '0;
        if (a_ready) begin
            cmd_d.v    = 1'b1;
            cmd_d.id   = REQ_A;
            cmd_d.we   = a_we;
            cmd_d.addr = a_addr;
            cmd_d.wd   = a_wd;
        end else if (b_ready) begin
            cmd_d.v    = 1'b1;
            cmd_d.id   = REQ_B;
            cmd_d.we   = b_we;
            cmd_d.addr = b_addr;
            cmd_d.wd   = b_wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q <= '0;
        end else begin
            cmd_q <= cmd_d;
        end
    end

    assign mem_we  = cmd_q.v & cmd_q.we;
    assign mem_rwa = cmd_q.v ? cmd_q.addr : '0;
    assign mem_wd  = cmd_q.v ? cmd_q.wd   : '0;

    // Memory read is combinational, so a write still returns the old word here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rsp_valid <= 1'b0;
            b_rsp_valid <= 1'b0;
            a_rdata     <= '0;
            b_rdata     <= '0;
        end else begin
            a_rsp_valid <= cmd_q.v && (cmd_q.id == REQ_A);
            b_rsp_valid <= cmd_q.v && (cmd_q.id == REQ_B);
            if (cmd_q.v && (cmd_q.id == REQ_A)) begin
                a_rdata <= mem_rwd;
            end
            if (cmd_q.v && (cmd_q.id == REQ_B)) begin
                b_rdata <= mem_rwd;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural memory, transaction-level reference model, random and directed traffic.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int CAP   = 64;
    localparam int LIMIT = 300;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic        a_we = 1'b0, b_we = 1'b0;
    logic        a_lock = 1'b0, b_lock = 1'b0;
    logic [31:0] a_addr = '0, b_addr = '0, a_wd = '0, b_wd = '0;
    logic        a_ready, b_ready, a_rsp_valid, b_rsp_valid, mem_we;
    logic [31:0] a_rdata, b_rdata, mem_rwa, mem_wd, mem_rwd;

    logic [31:0] hmem [CAP] = '{default: 32'h0};
    logic [31:0] gmem [CAP] = '{default: 32'h0};

    int checks = 0;
    int errors = 0;
    int glog[$];

    logic        m_v = 1'b0, m_we = 1'b0;
    int          m_id = 0;
    logic [31:0] m_addr = '0, m_wd = '0, m_data = '0;
    logic        r_v = 1'b0;
    int          r_id = 0;
    logic [31:0] r_data = '0;
    logic [31:0] ea = '0, eb = '0;
    int          mrr = 1;
    int          mlock = 0;

    int          na, nb, n;
    logic [31:0] d;

    always #5 clk = ~clk;

    mem_arbiter #(.CAPACITY(CAP)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .a_we        (a_we),
        .a_addr      (a_addr),
        .a_wd        (a_wd),
        .a_lock      (a_lock),
        .a_rsp_valid (a_rsp_valid),
        .a_rdata     (a_rdata),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .b_we        (b_we),
        .b_addr      (b_addr),
        .b_wd        (b_wd),
        .b_lock      (b_lock),
        .b_rsp_valid (b_rsp_valid),
        .b_rdata     (b_rdata),
        .mem_we      (mem_we),
        .mem_rwa     (mem_rwa),
        .mem_wd      (mem_wd),
        .mem_rwd     (mem_rwd)
    );

    // Memory block stand-in: combinational read, out-of-range reads 0 and ignores writes.
    assign mem_rwd = (mem_rwa < 32'(CAP)) ? hmem[mem_rwa[5:0]] : 32'h0;
    always @(posedge clk) if (mem_we && mem_rwa < 32'(CAP)) hmem[mem_rwa[5:0]] <= mem_wd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int glog_at(input int i);
        return (i < glog.size()) ? glog[i] : 99;
    endfunction

    // Transaction-level model, evaluated once per cycle at the falling edge.
    task automatic monitor_cycle();
        logic ga, gb;
        int   tid;
        if (!rst_n) begin
            chk("rst_a_ready", a_ready, 0);
            chk("rst_b_ready", b_ready, 0);
            chk("rst_a_rsp_valid", a_rsp_valid, 0);
            chk("rst_b_rsp_valid", b_rsp_valid, 0);
            chk("rst_a_rdata", a_rdata, 0);
            chk("rst_b_rdata", b_rdata, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_mem_rwa", mem_rwa, 0);
            chk("rst_mem_wd", mem_wd, 0);
            m_v = 1'b0; r_v = 1'b0; ea = '0; eb = '0; mrr = 1; mlock = 0;
            return;
        end
        ga = a_valid && (mlock != 2);
        gb = b_valid && (mlock != 1);
        if (ga && gb) begin
            if (mrr == 0) ga = 1'b0;
            else          gb = 1'b0;
        end
        chk("a_ready", a_ready, ga);
        chk("b_ready", b_ready, gb);
        chk("mem_we", mem_we, m_v && m_we);
        chk("mem_rwa", mem_rwa, m_v ? m_addr : 32'h0);
        chk("mem_wd", mem_wd, m_v ? m_wd : 32'h0);
        chk("a_rsp_valid", a_rsp_valid, r_v && r_id == 0);
        chk("b_rsp_valid", b_rsp_valid, r_v && r_id == 1);
        if (r_v) begin
            if (r_id == 0) ea = r_data;
            else           eb = r_data;
        end
        chk("a_rdata", a_rdata, ea);
        chk("b_rdata", b_rdata, eb);
        r_v = m_v; r_id = m_id; r_data = m_data;
        m_v = 1'b0;
        tid = -1;
        if (a_valid && a_ready)      tid = 0;
        else if (b_valid && b_ready) tid = 1;
        if (tid >= 0) begin
            m_v    = 1'b1;
            m_id   = tid;
            m_we   = (tid == 0) ? a_we   : b_we;
            m_addr = (tid == 0) ? a_addr : b_addr;
            m_wd   = (tid == 0) ? a_wd   : b_wd;
            m_data = (m_addr < 32'(CAP)) ? gmem[m_addr[5:0]] : 32'h0;
            if (m_we && m_addr < 32'(CAP)) gmem[m_addr[5:0]] = m_wd;
            mrr = tid;
`ifdef MEM_ARB_LOCK_EN
            mlock = ((tid == 0) ? a_lock : b_lock) ? tid + 1 : 0;
`endif
            glog.push_back(tid);
        end
    endtask

    task automatic issue_a(input logic w, input logic [31:0] ad, input logic [31:0] wd,
                           input logic l, output int cnt);
        a_valid = 1'b1; a_we = w; a_addr = ad; a_wd = wd; a_lock = l;
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!a_ready && cnt < LIMIT);
        chk("a_accept_timeout", a_ready, 1);
        @(posedge clk); #1;
        a_valid = 1'b0;
    endtask

    task automatic issue_b(input logic w, input logic [31:0] ad, input logic [31:0] wd,
                           input logic l, output int cnt);
        b_valid = 1'b1; b_we = w; b_addr = ad; b_wd = wd; b_lock = l;
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!b_ready && cnt < LIMIT);
        chk("b_accept_timeout", b_ready, 1);
        @(posedge clk); #1;
        b_valid = 1'b0;
    endtask

    task automatic wait_rsp_a(output logic [31:0] data, output int cnt);
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!a_rsp_valid && cnt < 8);
        chk("a_rsp_timeout", a_rsp_valid, 1);
        data = a_rdata;
        @(posedge clk); #1;
    endtask

    task automatic wait_rsp_b(output logic [31:0] data, output int cnt);
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!b_rsp_valid && cnt < 8);
        chk("b_rsp_timeout", b_rsp_valid, 1);
        data = b_rdata;
        @(posedge clk); #1;
    endtask

    task automatic rand_a(input int num);
        int gap, c;
        logic w, l;
        logic [31:0] ad, wd;
        for (int i = 0; i < num; i++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) begin @(posedge clk); #1; end
            w  = 1'($urandom_range(0, 1));
            ad = 32'($urandom_range(0, 79));
            wd = $urandom;
            l  = (i == num - 1) ? 1'b0 : 1'($urandom_range(0, 3) == 0);
            issue_a(w, ad, wd, l, c);
        end
    endtask

    task automatic rand_b(input int num);
        int gap, c;
        logic w, l;
        logic [31:0] ad, wd;
        for (int i = 0; i < num; i++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) begin @(posedge clk); #1; end
            w  = 1'($urandom_range(0, 1));
            ad = 32'($urandom_range(0, 79));
            wd = $urandom;
            l  = (i == num - 1) ? 1'b0 : 1'($urandom_range(0, 3) == 0);
            issue_b(w, ad, wd, l, c);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            forever begin
                @(negedge clk);
                monitor_cycle();
            end
            begin
                // Both requesters hold reads from reset: grants must alternate from A.
                fork
                    begin repeat (3) begin @(posedge clk); #1; end rst_n = 1'b1; end
                    begin for (int i = 0; i < 4; i++) issue_a(1'b0, 32'(i), 32'h0, 1'b0, na); end
                    begin for (int i = 0; i < 4; i++) issue_b(1'b0, 32'(10 + i), 32'h0, 1'b0, nb); end
                join
                chk("alt_grant0", glog_at(0), 0);
                chk("alt_grant1", glog_at(1), 1);
                chk("alt_grant2", glog_at(2), 0);
                chk("alt_grant3", glog_at(3), 1);
                repeat (3) begin @(posedge clk); #1; end

                // A alone writes 0xAA to 5, then reads it back.
                issue_a(1'b1, 32'd5, 32'hAA, 1'b0, n);
                chk("wr_ready_same_cycle", n, 1);
                @(negedge clk);
                chk("wr_t1_mem_we", mem_we, 1);
                chk("wr_t1_mem_rwa", mem_rwa, 5);
                chk("wr_t1_mem_wd", mem_wd, 32'hAA);
                wait_rsp_a(d, n);
                chk("wr_rsp_latency", n + 1, 2);
                chk("wr_rsp_old_data", d, 0);
                issue_a(1'b0, 32'd5, 32'h0, 1'b0, n);
                wait_rsp_a(d, n);
                chk("rd_rsp_latency", n, 2);
                chk("rd_back_aa", d, 32'hAA);

                // Write by A immediately followed by B read of the same word.
                issue_a(1'b1, 32'd3, 32'h11, 1'b0, n);
                issue_b(1'b0, 32'd3, 32'h0, 1'b0, n);
                chk("b_next_cycle_ready", n, 1);
                wait_rsp_b(d, n);
                chk("raw_b_sees_11", d, 32'h11);

                // Out-of-range accesses.
                issue_a(1'b1, 32'd36, 32'h36, 1'b0, n);
                wait_rsp_a(d, n);
                issue_b(1'b0, 32'd64, 32'h0, 1'b0, n);
                wait_rsp_b(d, n);
                chk("oor_read_zero", d, 0);
                issue_b(1'b1, 32'd100, 32'hFF, 1'b0, n);
                wait_rsp_b(d, n);
                chk("oor_write_rsp_zero", d, 0);
                issue_b(1'b0, 32'd36, 32'h0, 1'b0, n);
                wait_rsp_b(d, n);
                chk("oor_no_alias_36", d, 32'h36);

                // A issues lock 1,1,0 while B holds valid.
                glog.delete();
                fork
                    begin
                        issue_a(1'b0, 32'd1, 32'h0, 1'b1, na);
                        issue_a(1'b0, 32'd2, 32'h0, 1'b1, na);
                        issue_a(1'b0, 32'd3, 32'h0, 1'b0, na);
                    end
                    issue_b(1'b0, 32'd4, 32'h0, 1'b0, nb);
                join
`ifdef MEM_ARB_LOCK_EN
                chk("lock_seq0", glog_at(0), 0);
                chk("lock_seq1", glog_at(1), 0);
                chk("lock_seq2", glog_at(2), 0);
                chk("lock_seq3", glog_at(3), 1);
                chk("lock_b_wait", nb, 4);
`else
                chk("nolock_seq0", glog_at(0), 0);
                chk("nolock_seq1", glog_at(1), 1);
                chk("nolock_seq2", glog_at(2), 0);
                chk("nolock_seq3", glog_at(3), 0);
                chk("nolock_b_wait", nb, 2);
`endif
                repeat (3) begin @(posedge clk); #1; end

                fork
                    rand_a(150);
                    rand_b(150);
                join
                repeat (4) begin @(posedge clk); #1; end

                // Reset one cycle after an accepted read: no response, A wins afterwards.
                issue_a(1'b0, 32'd5, 32'h0, 1'b0, n);
                rst_n = 1'b0;
                na = 0;
                repeat (4) begin @(negedge clk); if (a_rsp_valid) na++; end
                chk("rst_no_inflight_rsp", na, 0);
                @(posedge clk); #1;
                glog.delete();
                rst_n = 1'b1;
                fork
                    issue_a(1'b0, 32'd6, 32'h0, 1'b0, na);
                    issue_b(1'b0, 32'd7, 32'h0, 1'b0, nb);
                join
                chk("post_rst_first_a", glog_at(0), 0);
                repeat (4) begin @(posedge clk); #1; end
            end
        join_any
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
